// File: rtl/uart_rx_frame_if.sv
// Output word handshake for uart_rx_frame: data word plus error flags with valid/ready.
// The receiver drives the master side; the byte consumer uses the slave side.
interface uart_rx_frame_if #(
    parameter int DBITS = 8
);
    logic [DBITS-1:0] rxdata;
    logic             rxvalid;
    logic             rxready;
    logic             perr;
    logic             ferr;

    modport master (output rxdata, rxvalid, perr, ferr, input rxready);
    modport slave  (input rxdata, rxvalid, perr, ferr, output rxready);
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver with configurable frame format and a valid/ready output buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT FIFO; otherwise a single holding register.
module uart_rx_frame #(
    parameter int SCYCLE     = 50_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int DBITS      = 8,
    parameter int PARITY     = 0,
    parameter int STOPBITS   = 1,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rx_i,
    uart_rx_frame_if.master rx_o,
    output logic            rxbusy_o,
    output logic            overrun_o
);
    localparam int DIV  = SCYCLE / (BAUDRATE * OVS);
    localparam int DIVW = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam int SUBW = $clog2(OVS);
    localparam int FW   = DBITS + 2;

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_frame: SCYCLE/(BAUDRATE*OVS) must be >= 2");
        end
        if (DBITS < 5 || DBITS > 9 || PARITY > 2 || STOPBITS < 1 || STOPBITS > 2
            || OVS < 8 || (OVS % 2) != 0) begin : g_bad_fmt
            $error("uart_rx_frame: unsupported frame format parameters");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_rx_frame: FIFO_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    state_e            state_q;
    logic              rx_meta_q, rxs_q;
    logic [DIVW-1:0]   div_q;
    logic [SUBW-1:0]   sub_q;
    logic [3:0]        bcnt_q;
    logic              s0_q, s1_q;
    logic [DBITS-1:0]  data_q;
    logic              perr_q, ferr_q;
    logic              overrun_q;

    logic              tick, resolve, sample, push, full, pop;
    logic [FW-1:0]     push_word, out_word;
    logic              out_vld;

    assign tick    = (state_q != S_IDLE) && (div_q == DIVW'(DIV - 1));
    assign resolve = tick && (sub_q == SUBW'(OVS / 2 + 1));
    // Third vote is the live synchronised value at the resolving sub-count.
    assign sample  = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign push    = resolve && (state_q == S_STOP) && (bcnt_q == 4'(STOPBITS - 1));
    assign push_word = {perr_q, ferr_q | ~sample, data_q};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= '0;
            sub_q     <= '0;
            bcnt_q    <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rxs_q     <= rx_meta_q;

            // Bit timing restarts from the start edge so mid-bit sampling stays centred.
            if (state_q == S_IDLE) begin
                div_q <= '0;
                sub_q <= '0;
            end else if (tick) begin
                div_q <= '0;
                sub_q <= (sub_q == SUBW'(OVS - 1)) ? '0 : sub_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end

            if (tick && sub_q == SUBW'(OVS / 2 - 1)) s0_q <= rxs_q;
            if (tick && sub_q == SUBW'(OVS / 2))     s1_q <= rxs_q;

            case (state_q)
                S_IDLE: if (!rxs_q) begin
                    state_q <= S_START;
                    bcnt_q  <= '0;
                    perr_q  <= 1'b0;
                    ferr_q  <= 1'b0;
                end
                S_START: if (resolve) state_q <= sample ? S_IDLE : S_DATA;
                S_DATA: if (resolve) begin
                    data_q <= {sample, data_q[DBITS-1:1]};
                    if (bcnt_q == 4'(DBITS - 1)) begin
                        bcnt_q  <= '0;
                        state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                    end
                end
                S_PARITY: if (resolve) begin
                    perr_q  <= (PARITY == 1) ? (sample == ^data_q) : (sample != ^data_q);
                    state_q <= S_STOP;
                end
                S_STOP: if (resolve) begin
                    if (!sample) ferr_q <= 1'b1;
                    if (bcnt_q == 4'(STOPBITS - 1)) state_q <= S_IDLE;
                    else                            bcnt_q  <= bcnt_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wptr_q, rptr_q;
    logic          empty;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && rx_o.rxready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push && (!full || pop)) begin
                mem_q[wptr_q[AW-1:0]] <= push_word;
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

    assign out_vld  = !empty;
    assign out_word = mem_q[rptr_q[AW-1:0]];
`else
    logic [FW-1:0] hold_q;
    logic          hvld_q;

    assign full = hvld_q;
    assign pop  = hvld_q && rx_o.rxready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            hvld_q <= 1'b0;
        end else if (push && (!full || pop)) begin
            hold_q <= push_word;
            hvld_q <= 1'b1;
        end else if (pop) begin
            hvld_q <= 1'b0;
        end
    end

    assign out_vld  = hvld_q;
    assign out_word = hold_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) overrun_q <= 1'b0;
        else         overrun_q <= push && full && !pop;
    end

    assign rx_o.rxvalid = out_vld;
    assign rx_o.perr    = out_word[FW-1];
    assign rx_o.ferr    = out_word[FW-2];
    assign rx_o.rxdata  = out_word[DBITS-1:0];
    assign rxbusy_o     = (state_q != S_IDLE);
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench: three receivers (8N1, 7E1, 9O2) fed from bench-built serial frames.
module tb_uart_rx_frame;
    localparam int SC  = 1_600_000;
    localparam int BR  = 10_000;
    localparam int OVS = 16;
    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx  = 3'b111;
    logic [2:0] rdy = 3'b000;
    logic       busy8, ovr8, busy7, ovr7, busy9, ovr9;
    int         checks = 0;
    int         errors = 0;
    int         ovr_tot8 = 0;
    logic [10:0] sb0[$], sb1[$], sb2[$];

    always #5 clk = ~clk;

    uart_rx_frame_if #(.DBITS(8)) if8 ();
    uart_rx_frame_if #(.DBITS(7)) if7 ();
    uart_rx_frame_if #(.DBITS(9)) if9 ();
    assign if8.rxready = rdy[0];
    assign if7.rxready = rdy[1];
    assign if9.rxready = rdy[2];

    uart_rx_frame #(.SCYCLE(SC), .BAUDRATE(BR), .DBITS(8), .PARITY(0), .STOPBITS(1),
                    .OVS(OVS), .FIFO_DEPTH(4)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[0]), .rx_o(if8), .rxbusy_o(busy8), .overrun_o(ovr8));
    uart_rx_frame #(.SCYCLE(SC), .BAUDRATE(BR), .DBITS(7), .PARITY(2), .STOPBITS(1),
                    .OVS(OVS), .FIFO_DEPTH(4)) u7 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[1]), .rx_o(if7), .rxbusy_o(busy7), .overrun_o(ovr7));
    uart_rx_frame #(.SCYCLE(SC), .BAUDRATE(BR), .DBITS(9), .PARITY(1), .STOPBITS(2),
                    .OVS(OVS), .FIFO_DEPTH(4)) u9 (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx[2]), .rx_o(if9), .rxbusy_o(busy9), .overrun_o(ovr9));

    always @(negedge clk) if (ovr8) ovr_tot8 <= ovr_tot8 + 1;

    // {valid, perr, ferr, data zero-extended to 9 bits}
    function automatic logic [11:0] obs(input int ch);
        case (ch)
            0:       obs = {if8.rxvalid, if8.perr, if8.ferr, 1'b0, if8.rxdata};
            1:       obs = {if7.rxvalid, if7.perr, if7.ferr, 2'b0, if7.rxdata};
            default: obs = {if9.rxvalid, if9.perr, if9.ferr, if9.rxdata};
        endcase
    endfunction

    task automatic sb_push(input int ch, input logic [10:0] w);
        case (ch)
            0:       sb0.push_back(w);
            1:       sb1.push_back(w);
            default: sb2.push_back(w);
        endcase
    endtask

    function automatic logic [10:0] sb_pop(input int ch);
        sb_pop = 11'h7FF;
        case (ch)
            0:       if (sb0.size() > 0) sb_pop = sb0.pop_front();
            1:       if (sb1.size() > 0) sb_pop = sb1.pop_front();
            default: if (sb2.size() > 0) sb_pop = sb2.pop_front();
        endcase
    endfunction

    // Serialise one frame; zstop selects a stop bit to drive low (-1 = none).
    task automatic send(input int ch, input int dbits, input int par, input int stops,
                        input logic [8:0] d, input bit pflip, input int zstop,
                        input bit expect_word, input int idle);
        logic [15:0] fr;
        logic [8:0]  m;
        logic        p;
        int          n;
        m = 9'((1 << dbits) - 1);
        p = ^(d & m);
        if (par == 1) p = ~p;
        p  = p ^ pflip;
        fr = '0;
        n  = 1;
        for (int i = 0; i < dbits; i++) begin fr[n] = d[i]; n++; end
        if (par != 0) begin fr[n] = p; n++; end
        for (int i = 0; i < stops; i++) begin fr[n] = (i != zstop); n++; end
        if (expect_word) sb_push(ch, {pflip && (par != 0), zstop >= 0, d & m});
        for (int i = 0; i < n; i++) begin
            @(negedge clk) rx[ch] = fr[i];
            repeat (BIT - 1) @(negedge clk);
        end
        @(negedge clk) rx[ch] = 1'b1;
        repeat (idle) @(negedge clk);
    endtask

    // Wait (bounded) for a word, capture it, then complete one handshake.
    task automatic take(input int ch, output logic [10:0] got, output bit ok);
        logic [11:0] o;
        ok = 1'b0;
        o  = '0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            o = obs(ch);
            ok = o[11];
        end
        got = o[10:0];
        if (ok) begin
            @(posedge clk); #1 rdy[ch] = 1'b1;
            @(posedge clk); #1 rdy[ch] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({obs(0), busy8, ovr8} !== 14'b0) begin
            errors++; $display("FAIL reset_8n1 got %h want 0", {obs(0), busy8, ovr8});
        end
        checks++;
        if ({obs(1), busy7, ovr7} !== 14'b0) begin
            errors++; $display("FAIL reset_7e1 got %h want 0", {obs(1), busy7, ovr7});
        end
        checks++;
        if ({obs(2), busy9, ovr9} !== 14'b0) begin
            errors++; $display("FAIL reset_9o2 got %h want 0", {obs(2), busy9, ovr9});
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_8n1();
        logic [10:0] got, exp;
        bit ok, bad;
        @(posedge clk); #1 rdy[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rdy[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (obs(0)[11] !== 1'b0) begin
            errors++; $display("FAIL ready_noop valid=%b want 0", obs(0)[11]);
        end
        send(0, 8, 0, 1, 9'h0A5, 1'b0, -1, 1'b1, 20);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (obs(0) !== 12'h8A5) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_a5 got %h want 8a5", obs(0)); end
        take(0, got, ok);
        exp = sb_pop(0);
        checks++;
        if (!ok || got !== exp) begin
            errors++; $display("FAIL word_a5 got %h ok=%0b want %h", got, ok, exp);
        end
        @(negedge clk);
        checks++;
        if (obs(0)[11] !== 1'b0) begin errors++; $display("FAIL pop_a5 valid=%b want 0", obs(0)[11]); end
    endtask

    task automatic test_parity();
        logic [10:0] got, exp;
        bit ok;
        send(1, 7, 2, 1, 9'h03C, 1'b1, -1, 1'b1, 20);
        send(2, 9, 1, 2, 9'h1A5, 1'b0, -1, 1'b1, 20);
        take(1, got, ok); exp = sb_pop(1);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL perr_3c got %h want %h", got, exp); end
        take(2, got, ok); exp = sb_pop(2);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL odd_1a5 got %h want %h", got, exp); end
        send(1, 7, 2, 1, 9'h015, 1'b0, -1, 1'b1, 20);
        send(2, 9, 1, 2, 9'h0F0, 1'b1, 1, 1'b1, 2 * BIT);
        take(1, got, ok); exp = sb_pop(1);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL even_15 got %h want %h", got, exp); end
        take(2, got, ok); exp = sb_pop(2);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL stop2_0f0 got %h want %h", got, exp); end
    endtask

    task automatic test_framing();
        logic [10:0] got, exp;
        bit ok;
        send(0, 8, 0, 1, 9'h081, 1'b0, 0, 1'b1, 2 * BIT);
        take(0, got, ok); exp = sb_pop(0);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL ferr_81 got %h want %h", got, exp); end
        send(0, 8, 0, 1, 9'h055, 1'b0, -1, 1'b1, 20);
        take(0, got, ok); exp = sb_pop(0);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL after_ferr_55 got %h want %h", got, exp); end
    endtask

    task automatic test_glitch();
        int busy_n, vld_n, ovr0;
        ovr0 = ovr_tot8;
        busy_n = 0;
        vld_n  = 0;
        @(negedge clk) rx[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx[0] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy8) busy_n++;
            if (obs(0)[11]) vld_n++;
        end
        checks++;
        if (busy_n == 0 || busy_n > BIT) begin
            errors++; $display("FAIL glitch_busy cycles=%0d want 1..%0d", busy_n, BIT);
        end
        checks++;
        if (vld_n != 0) begin errors++; $display("FAIL glitch_valid cycles=%0d want 0", vld_n); end
        checks++;
        if (ovr_tot8 != ovr0) begin
            errors++; $display("FAIL glitch_overrun pulses=%0d want 0", ovr_tot8 - ovr0);
        end
    endtask

    task automatic test_overrun();
        logic [10:0] got, exp;
        bit ok;
        int ovr0, ovr1;
        logic [8:0] w;
`ifdef UART_RX_FIFO_EN
        localparam int KEEP = 4;
`else
        localparam int KEEP = 1;
`endif
        ovr0 = ovr_tot8;
        for (int i = 0; i < KEEP; i++) begin
            w = 9'(8'h11 * (i + 1));
            send(0, 8, 0, 1, w, 1'b0, -1, 1'b1, 20);
        end
        ovr1 = ovr_tot8;
        w = 9'(8'h11 * (KEEP + 1));
        send(0, 8, 0, 1, w, 1'b0, -1, 1'b0, 20);
        checks++;
        if (ovr1 != ovr0 || ovr_tot8 - ovr1 != 1) begin
            errors++; $display("FAIL overrun before=%0d at_drop=%0d want 0 and 1", ovr1 - ovr0, ovr_tot8 - ovr1);
        end
        checks++;
        if (obs(0) !== 12'h811) begin errors++; $display("FAIL overrun_hold got %h want 811", obs(0)); end
        for (int i = 0; i < KEEP; i++) begin
            take(0, got, ok); exp = sb_pop(0);
            checks++;
            if (!ok || got !== exp) begin
                errors++; $display("FAIL overrun_word%0d got %h want %h", i, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (obs(0)[11] !== 1'b0) begin errors++; $display("FAIL overrun_drain valid=%b want 0", obs(0)[11]); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] g1, g2, e1, e2;
        bit ok1, ok2;
        fork
            begin
                send(0, 8, 0, 1, 9'h05A, 1'b0, -1, 1'b1, 0);
                send(0, 8, 0, 1, 9'h0C3, 1'b0, -1, 1'b1, 20);
            end
            begin
                take(0, g1, ok1);
                take(0, g2, ok2);
            end
        join
        e1 = sb_pop(0);
        e2 = sb_pop(0);
        checks++;
        if (!ok1 || g1 !== e1) begin errors++; $display("FAIL b2b_first got %h want %h", g1, e1); end
        checks++;
        if (!ok2 || g2 !== e2) begin errors++; $display("FAIL b2b_second got %h want %h", g2, e2); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] got, exp;
        bit ok;
        send(0, 8, 0, 1, 9'h0EE, 1'b0, -1, 1'b0, 20);
        @(negedge clk) rx[0] = 1'b0;
        repeat (BIT) @(negedge clk);
        rx[0] = 1'b1;
        repeat (3 * BIT + 40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs(0), busy8, ovr8} !== 14'b0) begin
            errors++; $display("FAIL reset_mid got %h want 0", {obs(0), busy8, ovr8});
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send(0, 8, 0, 1, 9'h03F, 1'b0, -1, 1'b1, 20);
        take(0, got, ok); exp = sb_pop(0);
        checks++;
        if (!ok || got !== exp) begin errors++; $display("FAIL after_reset_3f got %h want %h", got, exp); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_glitch();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb0.size() + sb1.size() + sb2.size() != 0) begin
            errors++; $display("FAIL scoreboard_left %0d words want 0", sb0.size() + sb1.size() + sb2.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
